hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and stall controller for the five-stage MCU pipeline (IF/ID/EXE/MEM/WB).
- Drives the per-stage enable and squash controls and the `rs1_depended` stall indication.
- Keeps a shift-register scoreboard of in-flight destination registers (EXE, MEM, WB slots).
- Resolves load-use hazards, ID-stage branch redirection, external memory stalls, and the forwarding/no-forwarding mode; counts stall and flush events.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall controller for the IF/ID/EXE/MEM/WB pipeline.
// A three-slot scoreboard (E, M, W) tracks in-flight destination registers;
// the slot index doubles as the producer's age (E=0, M=1, W=2). ID-stage
// sources are resolved youngest-first, and a match that cannot be forwarded
// yet holds IF/ID and injects a bubble into EXE.
module hazard_ctrl #(
    parameter int REG_IDX_W = 5,
    parameter int FWD_EN    = 1,
    parameter int LOAD_LAT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rs1_idx_d_i,
    input  logic [REG_IDX_W-1:0] rs2_idx_d_i,
    input  logic                 rs1_used_d_i,
    input  logic                 rs2_used_d_i,
    input  logic [REG_IDX_W-1:0] rd_idx_d_i,
    input  logic                 reg_write_en_d_i,
    input  logic                 is_load_d_i,
    input  logic                 valid_d_i,
    input  logic                 taken_d_i,
    input  logic                 ext_stall_i,
    output logic                 enable_f_o,
    output logic                 enable_d_o,
    output logic                 bubble_e_o,
    output logic                 flush_d_o,
    output logic [1:0]           rs1_fwd_sel_d_o,
    output logic [1:0]           rs2_fwd_sel_d_o,
    output logic                 rs1_depended_h_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam int N_SLOT = 3;

    typedef logic [N_SLOT-1:0][REG_IDX_W-1:0] rd_vec_t;

    // slot 0 = E, slot 1 = M, slot 2 = W
    logic [N_SLOT-1:0] slot_valid;
    logic [N_SLOT-1:0] slot_load;
    rd_vec_t           slot_rd;

    logic [2:0]           rs1_res;
    logic [2:0]           rs2_res;
    logic                 rs1_haz;
    logic                 rs2_haz;
    logic [1:0]           rs1_sel;
    logic [1:0]           rs2_sel;
    logic                 hazard;
    logic                 e_valid;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    // Without forwarding nothing is usable until the producer has left WB.
    // A load result only appears LOAD_LAT cycles after EXE.
    function automatic logic fwdable(input int age, input logic load);
        return (FWD_EN != 0) && (!load || (age >= LOAD_LAT));
    endfunction

    // Returns {hazard, sel}. Walks oldest to youngest so the youngest match
    // is the one left standing.
    function automatic logic [2:0] resolve(
        input logic [REG_IDX_W-1:0] src,
        input logic                 used,
        input logic [N_SLOT-1:0]    vld,
        input rd_vec_t              rd,
        input logic [N_SLOT-1:0]    ld
    );
        logic [2:0] r;
        r = 3'b000;
        for (int a = N_SLOT - 1; a >= 0; a--) begin
            if (vld[a] && used && (src != '0) && (rd[a] == src)) begin
                if (fwdable(a, ld[a])) begin
                    r = {1'b0, 2'(a + 1)};
                end else begin
                    r = 3'b100;
                end
            end
        end
        return r;
    endfunction

    assign rs1_res = resolve(rs1_idx_d_i, rs1_used_d_i, slot_valid, slot_rd, slot_load);
    assign rs2_res = resolve(rs2_idx_d_i, rs2_used_d_i, slot_valid, slot_rd, slot_load);
    assign rs1_haz = rs1_res[2];
    assign rs2_haz = rs2_res[2];
    assign rs1_sel = rs1_res[1:0];
    assign rs2_sel = rs2_res[1:0];
    assign hazard  = valid_d_i & (rs1_haz | rs2_haz);

    // A stalled ID instruction must not enter E; a bubble goes in instead.
    assign e_valid = ~hazard & valid_d_i & reg_write_en_d_i & (rd_idx_d_i != '0);

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

    // Pipeline control: reset beats freeze, freeze beats hazard, hazard beats redirect.
    always_comb begin
        enable_f_o       = 1'b1;
        enable_d_o       = 1'b1;
        bubble_e_o       = 1'b0;
        flush_d_o        = 1'b0;
        rs1_fwd_sel_d_o  = hazard ? 2'd0 : rs1_sel;
        rs2_fwd_sel_d_o  = hazard ? 2'd0 : rs2_sel;
        rs1_depended_h_o = valid_d_i & rs1_haz;
        if (reset) begin
            enable_f_o       = 1'b0;
            enable_d_o       = 1'b0;
            bubble_e_o       = 1'b1;
            flush_d_o        = 1'b1;
            rs1_fwd_sel_d_o  = 2'd0;
            rs2_fwd_sel_d_o  = 2'd0;
            rs1_depended_h_o = 1'b0;
        end else if (ext_stall_i) begin
            enable_f_o = 1'b0;
            enable_d_o = 1'b0;
        end else if (hazard) begin
            enable_f_o = 1'b0;
            enable_d_o = 1'b0;
            bubble_e_o = 1'b1;
        end else begin
            flush_d_o = taken_d_i;
        end
    end

    // Scoreboard shift and event counters; everything holds while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            slot_load  <= '0;
            slot_rd    <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (!ext_stall_i) begin
            slot_valid <= {slot_valid[N_SLOT-2:0], e_valid};
            slot_load  <= {slot_load[N_SLOT-2:0], is_load_d_i & e_valid};
            slot_rd    <= {slot_rd[N_SLOT-2:0], rd_idx_d_i};
            if (hazard) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else if (taken_d_i) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (forwarding with LOAD_LAT=1,
// forwarding with LOAD_LAT=2, no forwarding) share one input stream. Each is
// checked every cycle against a model that keeps the in-flight producers as a
// list ordered by age, plus literal expectations in the directed scenarios.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1_idx, rs2_idx, rd_idx;
    logic       rs1_used, rs2_used, reg_we, is_load, valid, taken, ext_stall;

    logic [2:0]  en_f, en_d, bub, fl, dep;
    logic [1:0]  s1o  [3];
    logic [1:0]  s2o  [3];
    logic [15:0] scnt [3];
    logic [15:0] fcnt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl #(
            .REG_IDX_W(5),
            .FWD_EN   ((g == 2) ? 0 : 1),
            .LOAD_LAT ((g == 1) ? 2 : 1),
            .CNT_W    (16)
        ) dut (
            .clk             (clk),
            .reset           (reset),
            .rs1_idx_d_i     (rs1_idx),
            .rs2_idx_d_i     (rs2_idx),
            .rs1_used_d_i    (rs1_used),
            .rs2_used_d_i    (rs2_used),
            .rd_idx_d_i      (rd_idx),
            .reg_write_en_d_i(reg_we),
            .is_load_d_i     (is_load),
            .valid_d_i       (valid),
            .taken_d_i       (taken),
            .ext_stall_i     (ext_stall),
            .enable_f_o      (en_f[g]),
            .enable_d_o      (en_d[g]),
            .bubble_e_o      (bub[g]),
            .flush_d_o       (fl[g]),
            .rs1_fwd_sel_d_o (s1o[g]),
            .rs2_fwd_sel_d_o (s2o[g]),
            .rs1_depended_h_o(dep[g]),
            .stall_cnt_o     (scnt[g]),
            .flush_cnt_o     (fcnt[g])
        );
    end

    int checks = 0;
    int failures = 0;

    // in-flight producers per instance, indexed by age (cycles since leaving ID)
    int p_v  [3][3];
    int p_rd [3][3];
    int p_ld [3][3];
    int m_sc [3];
    int m_fc [3];

    function automatic int fe(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic int ll(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    // youngest producer of src decides: forward from it, or wait for it
    task automatic look(input int k, input int src, input int used, output int haz, output int sel);
        bit found;
        haz = 0;
        sel = 0;
        found = 0;
        if (used != 0 && src != 0) begin
            for (int age = 0; age < 3; age++) begin
                if (!found && p_v[k][age] != 0 && p_rd[k][age] == src) begin
                    found = 1;
                    if (fe(k) == 1 && (p_ld[k][age] == 0 || age >= ll(k))) sel = age + 1;
                    else haz = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int h1, h2, s1, s2, haz;
            int ef, ed, eb, efl, e1, e2, edp;
            look(k, int'(rs1_idx), int'(rs1_used), h1, s1);
            look(k, int'(rs2_idx), int'(rs2_used), h2, s2);
            haz = (valid && (h1 != 0 || h2 != 0)) ? 1 : 0;
            if (reset) begin
                ef = 0; ed = 0; eb = 1; efl = 1; e1 = 0; e2 = 0; edp = 0;
            end else begin
                edp = (valid && h1 != 0) ? 1 : 0;
                e1  = haz ? 0 : s1;
                e2  = haz ? 0 : s2;
                if (ext_stall) begin
                    ef = 0; ed = 0; eb = 0; efl = 0;
                end else if (haz != 0) begin
                    ef = 0; ed = 0; eb = 1; efl = 0;
                end else begin
                    ef = 1; ed = 1; eb = 0; efl = int'(taken);
                end
            end
            chk("enable_f", k, int'(en_f[k]), ef);
            chk("enable_d", k, int'(en_d[k]), ed);
            chk("bubble_e", k, int'(bub[k]), eb);
            chk("flush_d", k, int'(fl[k]), efl);
            chk("rs1_sel", k, int'(s1o[k]), e1);
            chk("rs2_sel", k, int'(s2o[k]), e2);
            chk("rs1_dep", k, int'(dep[k]), edp);
            chk("stall_cnt", k, int'(scnt[k]), m_sc[k]);
            chk("flush_cnt", k, int'(fcnt[k]), m_fc[k]);
            if (reset) begin
                for (int a = 0; a < 3; a++) p_v[k][a] = 0;
                m_sc[k] = 0;
                m_fc[k] = 0;
            end else if (!ext_stall) begin
                if (haz != 0) m_sc[k] = (m_sc[k] + 1) % 65536;
                else if (taken) m_fc[k] = (m_fc[k] + 1) % 65536;
                for (int a = 2; a > 0; a--) begin
                    p_v[k][a]  = p_v[k][a-1];
                    p_rd[k][a] = p_rd[k][a-1];
                    p_ld[k][a] = p_ld[k][a-1];
                end
                p_v[k][0]  = (haz == 0 && valid && reg_we && rd_idx != 0) ? 1 : 0;
                p_rd[k][0] = int'(rd_idx);
                p_ld[k][0] = int'(is_load);
            end
        end
    end

    task automatic set_id(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                          input int rd, input bit we, input bit ld, input bit tk);
        valid    = v;
        rs1_idx  = 5'(r1);
        rs1_used = u1;
        rs2_idx  = 5'(r2);
        rs2_used = u2;
        rd_idx   = 5'(rd);
        reg_we   = we;
        is_load  = ld;
        taken    = tk;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        step(); idle();
        step(); step(); step();
    endtask

    initial begin
        reset = 1'b1;
        ext_stall = 1'b0;
        idle();
        step(); step();
        mid();
        chk("rst_enable_d", 0, int'(en_d[0]), 0);
        chk("rst_bubble", 0, int'(bub[0]), 1);
        chk("rst_flush", 0, int'(fl[0]), 1);
        chk("rst_dep", 0, int'(dep[0]), 0);
        step(); reset = 1'b0;
        mid();
        chk("post_rst_enable_d", 0, int'(en_d[0]), 1);
        chk("post_rst_bubble", 0, int'(bub[0]), 0);
        chk("post_rst_flush", 0, int'(fl[0]), 0);

        // add x5 ; sub x6,x5,x1 held four cycles
        step(); set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(); set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
        mid();
        chk("b2b_rs1_sel", 0, int'(s1o[0]), 1);
        chk("b2b_enable_d", 0, int'(en_d[0]), 1);
        chk("nofwd_enable_d", 2, int'(en_d[2]), 0);
        step(); step(); step();
        mid();
        chk("nofwd_release_en", 2, int'(en_d[2]), 1);
        chk("nofwd_release_sel", 2, int'(s1o[2]), 0);
        chk("nofwd_stall_cnt", 2, int'(scnt[2]), 3);
        chk("b2b_stall_cnt", 0, int'(scnt[0]), 0);
        drain();

        // lw x7 ; add x8,x7,x7
        step(); set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(); set_id(1, 7, 1, 7, 1, 8, 1, 0, 0);
        mid();
        chk("lu_enable_f", 0, int'(en_f[0]), 0);
        chk("lu_enable_d", 0, int'(en_d[0]), 0);
        chk("lu_bubble", 0, int'(bub[0]), 1);
        chk("lu_dep", 0, int'(dep[0]), 1);
        step(); mid();
        chk("lu_rs1_sel", 0, int'(s1o[0]), 2);
        chk("lu_rs2_sel", 0, int'(s2o[0]), 2);
        chk("lu_stall_cnt", 0, int'(scnt[0]), 1);
        chk("lu2_still_stall", 1, int'(en_d[1]), 0);
        step(); mid();
        chk("lu2_rs1_sel", 1, int'(s1o[1]), 3);
        chk("lu2_rs2_sel", 1, int'(s2o[1]), 3);
        chk("lu2_stall_cnt", 1, int'(scnt[1]), 2);
        step();
        drain();

        // redirect pulse with nothing in flight
        step(); set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        mid();
        for (int k = 0; k < 3; k++) chk("redir_flush", k, int'(fl[k]), 1);
        step(); idle();
        mid();
        chk("redir_flush_drop", 0, int'(fl[0]), 0);
        chk("redir_flush_cnt", 0, int'(fcnt[0]), 1);
        chk("redir_flush_cnt", 2, int'(fcnt[2]), 1);

        // redirect held across a load-use stall
        step(); set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(); set_id(1, 7, 1, 7, 1, 8, 1, 0, 1);
        mid();
        chk("redir_in_stall", 0, int'(fl[0]), 0);
        step(); mid();
        chk("redir_after_stall", 0, int'(fl[0]), 1);
        drain();

        // freeze four cycles over a load-use hazard
        step(); set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(); set_id(1, 7, 1, 7, 1, 8, 1, 0, 0); ext_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            mid();
            chk("frz_enable_f", 0, int'(en_f[0]), 0);
            chk("frz_enable_d", 0, int'(en_d[0]), 0);
            chk("frz_bubble", 0, int'(bub[0]), 0);
            chk("frz_stall_cnt", 0, int'(scnt[0]), 2);
        end
        step(); ext_stall = 1'b0;
        mid();
        chk("frz_rel_enable_d", 0, int'(en_d[0]), 0);
        chk("frz_rel_bubble", 0, int'(bub[0]), 1);
        step(); mid();
        chk("frz_rel_sel", 0, int'(s1o[0]), 2);
        chk("frz_rel_stall_cnt", 0, int'(scnt[0]), 3);
        drain();

        // producer to x0 never creates a dependency
        step(); set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
        step(); set_id(1, 0, 1, 0, 1, 9, 1, 0, 0);
        mid();
        chk("x0_enable_d", 2, int'(en_d[2]), 1);
        chk("x0_enable_d", 0, int'(en_d[0]), 1);
        chk("x0_rs1_sel", 0, int'(s1o[0]), 0);
        drain();

        // reset in the middle of a load-use stall
        step(); set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(); set_id(1, 7, 1, 7, 1, 8, 1, 0, 0);
        mid();
        chk("pre_rst_stall", 0, int'(en_d[0]), 0);
        step(); reset = 1'b1;
        mid();
        chk("mid_rst_enable_f", 0, int'(en_f[0]), 0);
        chk("mid_rst_bubble", 0, int'(bub[0]), 1);
        chk("mid_rst_flush", 0, int'(fl[0]), 1);
        chk("mid_rst_dep", 0, int'(dep[0]), 0);
        step(); reset = 1'b0;
        mid();
        chk("after_rst_enable_d", 0, int'(en_d[0]), 1);
        chk("after_rst_enable_d", 2, int'(en_d[2]), 1);
        chk("after_rst_stall_cnt", 0, int'(scnt[0]), 0);

        // random traffic over a small register set to provoke dependencies
        for (int n = 0; n < 2000; n++) begin
            step();
            reset     = ($urandom_range(0, 99) < 2);
            ext_stall = ($urandom_range(0, 99) < 10);
            set_id($urandom_range(0, 99) < 85,
                   int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15);
        end
        step();
        reset = 1'b0;
        ext_stall = 1'b0;
        idle();
        mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
